branch_unit: RTL and testbench

//   Branch-decision logic for the accumulator CPU control path.
//   - Combines the current opcode, the ALU flags (carry, zero) and the sequencer's jump strobe.
//   - Decides whether the PC is loaded with the jump target this cycle.
//   - Sits between the instruction decoder/sequencer and the program counter load input.
//   - Also provides a registered copy of the decision for tracing and pipeline use.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/branch_unit.sv | 44 ++++
 tb/tb_branch_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the accumulator CPU control path: widths, opcode map, flag indices.
package cpu_pkg;

   localparam int unsigned OP_W   = 3;
   localparam int unsigned FLAG_W = 2;

   localparam logic [OP_W-1:0] OP_LDA = 3'b010;
   localparam logic [OP_W-1:0] OP_JMP = 3'b100;
   localparam logic [OP_W-1:0] OP_JZ  = 3'b101;
   localparam logic [OP_W-1:0] OP_JC  = 3'b110;

   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_Z = 0;

endpackage

// File: rtl/branch_unit.sv
// Branch decision: decodes opcode against ALU flags, gates with the sequencer jump strobe,
// and keeps a registered copy of the decision.
module branch_unit
   import cpu_pkg::OP_JMP;
   import cpu_pkg::OP_JZ;
   import cpu_pkg::OP_JC;
   import cpu_pkg::FLAG_C;
   import cpu_pkg::FLAG_Z;
#(
   parameter int unsigned OP_W   = cpu_pkg::OP_W,
   parameter int unsigned FLAG_W = cpu_pkg::FLAG_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [OP_W-1:0]   op_i,
   input  logic [FLAG_W-1:0] flags_i,
   input  logic              ctrl_jmp_i,
   output logic              branch_o,
   output logic              branch_q_o,
   output logic              cond_o
);

   // Unlisted and unknown opcodes fall to the default, so they can never request a branch.
   always_comb begin
      cond_o = 1'b0;
      case (op_i)
         OP_JMP:  cond_o = 1'b1;
         OP_JZ:   cond_o = flags_i[FLAG_Z];
         OP_JC:   cond_o = flags_i[FLAG_C];
         default: cond_o = 1'b0;
      endcase
   end

   assign branch_o = ctrl_jmp_i & cond_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         branch_q_o <= 1'b0;
      end else begin
         branch_q_o <= branch_o;
      end
   end

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit, finishing with an exhaustive input sweep.
module tb_branch_unit;

   logic       clk;
   logic       rst_n;
   logic [2:0] op;
   logic [1:0] flags;
   logic       ctrl_jmp;
   logic       branch;
   logic       branch_q;
   logic       cond;

   int vectors;
   int miscompares;

   branch_unit dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .op_i       (op),
      .flags_i    (flags),
      .ctrl_jmp_i (ctrl_jmp),
      .branch_o   (branch),
      .branch_q_o (branch_q),
      .cond_o     (cond)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent reference for the condition result.
   function automatic logic ref_cond(input logic [2:0] o, input logic [1:0] f);
      if (o == 3'b100) return 1'b1;
      if (o == 3'b101) return f[0];
      if (o == 3'b110) return f[1];
      return 1'b0;
   endfunction

   task automatic chk(input string tag, input logic observed, input logic expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b (op=%b flags=%b jmp=%b)",
                tag, observed, expected, op, flags, ctrl_jmp);
      end
   endtask

   task automatic drive(input logic [2:0] o, input logic [1:0] f, input logic j);
      op       = o;
      flags    = f;
      ctrl_jmp = j;
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      op          = 3'b000;
      flags       = 2'b00;
      ctrl_jmp    = 1'b0;
      #2;
      chk("reset_q", branch_q, 1'b0);
      // Comb path follows inputs even while in reset.
      drive(3'b100, 2'b00, 1'b1);
      chk("reset_comb_branch", branch, 1'b1);
      @(posedge clk); #1;
      chk("reset_hold_q", branch_q, 1'b0);
      drive(3'b000, 2'b00, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: unconditional jump and its registered copy
      drive(3'b100, 2'b00, 1'b1);
      chk("t1_branch", branch, 1'b1);
      chk("t1_cond", cond, 1'b1);
      @(posedge clk); #1;
      chk("t1_branch_q", branch_q, 1'b1);

      // 2: strobe low suppresses branch
      drive(3'b100, 2'b00, 1'b0);
      chk("t2_jmp_nostrobe", branch, 1'b0);
      chk("t2_jmp_cond", cond, 1'b1);
      drive(3'b101, 2'b01, 1'b0);
      chk("t2_jz_nostrobe", branch, 1'b0);
      @(posedge clk); #1;
      chk("t2_branch_q", branch_q, 1'b0);

      // 3: non-branching opcodes under every flag value
      for (int f = 0; f < 4; f++) begin
         drive(3'b010, 2'(f), 1'b1);
         chk("t3_lda_branch", branch, 1'b0);
         chk("t3_lda_cond", cond, 1'b0);
         drive(3'b111, 2'(f), 1'b1);
         chk("t3_rsv_branch", branch, 1'b0);
         chk("t3_rsv_cond", cond, 1'b0);
      end

      // 4: JZ
      drive(3'b101, 2'b01, 1'b1); chk("t4_jz_01", branch, 1'b1);
      drive(3'b101, 2'b10, 1'b1); chk("t4_jz_10", branch, 1'b0);
      drive(3'b101, 2'b00, 1'b1); chk("t4_jz_00", branch, 1'b0);

      // 5: JC
      drive(3'b110, 2'b10, 1'b1); chk("t5_jc_10", branch, 1'b1);
      drive(3'b110, 2'b00, 1'b1); chk("t5_jc_00", branch, 1'b0);
      drive(3'b110, 2'b01, 1'b1); chk("t5_jc_01", branch, 1'b0);
      drive(3'b110, 2'b11, 1'b1); chk("t5_jc_11", branch, 1'b1);

      // Unknown opcode must not branch
      drive(3'bxxx, 2'b11, 1'b1); chk("x_op_branch", branch, 1'b0);

      // 6: asynchronous reset mid-cycle
      @(negedge clk);
      drive(3'b100, 2'b00, 1'b1);
      @(posedge clk); #1;
      chk("t6_q_before", branch_q, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_q_async", branch_q, 1'b0);
      chk("t6_branch_in_reset", branch, 1'b1);
      @(posedge clk); #1;
      chk("t6_q_held", branch_q, 1'b0);
      #2;
      rst_n = 1'b1;
      #1;
      chk("t6_q_release", branch_q, 1'b0);
      @(posedge clk); #1;
      chk("t6_q_first_edge", branch_q, 1'b1);

      // Exhaustive sweep, including the registered copy one edge later
      for (int o = 0; o < 8; o++) begin
         for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < 2; j++) begin
               @(negedge clk);
               drive(3'(o), 2'(f), 1'(j));
               chk("sweep_cond", cond, ref_cond(3'(o), 2'(f)));
               chk("sweep_branch", branch, 1'(j) & ref_cond(3'(o), 2'(f)));
               @(posedge clk); #1;
               chk("sweep_q", branch_q, 1'(j) & ref_cond(3'(o), 2'(f)));
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
